// File: rtl/lc4_hazard_ctrl_if.sv
// Hazard controller bus: D/X stage hazard inputs and the stall/flush/trace outputs.
// The pipeline side (master) drives decode/execute info; the controller is the slave.
interface lc4_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             gwe;
    logic [2:0]       i_dec_r1sel;
    logic             i_dec_r1re;
    logic [2:0]       i_dec_r2sel;
    logic             i_dec_r2re;
    logic             i_dec_is_store;
    logic             i_dec_is_branch;
    logic             i_x_is_load;
    logic [2:0]       i_x_rdsel;
    logic             i_x_br_taken;
    logic             o_stall_fd;
    logic             o_bubble_dx;
    logic             o_flush;
    logic [1:0]       o_test_stall;
    logic [CNT_W-1:0] o_lu_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output gwe, i_dec_r1sel, i_dec_r1re, i_dec_r2sel, i_dec_r2re, i_dec_is_store,
               i_dec_is_branch, i_x_is_load, i_x_rdsel, i_x_br_taken,
        input  o_stall_fd, o_bubble_dx, o_flush, o_test_stall, o_lu_cnt, o_flush_cnt
    );

    modport slave (
        input  gwe, i_dec_r1sel, i_dec_r1re, i_dec_r2sel, i_dec_r2re, i_dec_is_store,
               i_dec_is_branch, i_x_is_load, i_x_rdsel, i_x_br_taken,
        output o_stall_fd, o_bubble_dx, o_flush, o_test_stall, o_lu_cnt, o_flush_cnt
    );
endinterface

// File: rtl/lc4_hazard_ctrl.sv
// LC4 5-stage pipeline hazard controller: load-use stall, taken-branch flush,
// per-instruction stall code carried D->X->M->W, saturating hazard event counters.
module lc4_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter bit          LD_BR_STALL = 1'b1
) (
    input logic              clk,
    input logic              rst,
    lc4_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] CodeReal  = 2'd0;
    localparam logic [1:0] CodeFlush = 2'd2;
    localparam logic [1:0] CodeLdUse = 2'd3;

    logic [1:0]       code_d, code_x, code_m, code_w;
    logic [CNT_W-1:0] lu_cnt, flush_cnt;

    logic x_valid;
    logic r1_hit, r2_hit, br_hit;
    logic lu, flush;

    // Hazard detection; bubbles in X never raise a hazard, flush wins over load-use.
    always_comb begin
        x_valid = (code_x == CodeReal);
        r1_hit  = bus.i_dec_r1re && (bus.i_dec_r1sel == bus.i_x_rdsel);
        // Store data is bypassed W->M, so a store's r2 never needs the stall.
        r2_hit  = bus.i_dec_r2re && (bus.i_dec_r2sel == bus.i_x_rdsel) && !bus.i_dec_is_store;
        br_hit  = LD_BR_STALL && bus.i_dec_is_branch;
        flush   = x_valid && bus.i_x_br_taken;
        lu      = x_valid && bus.i_x_is_load && !flush && (r1_hit || r2_hit || br_hit);
    end

    // Stall-code pipeline and event counters, advancing only when gwe is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_d    <= CodeFlush;
            code_x    <= CodeFlush;
            code_m    <= CodeFlush;
            code_w    <= CodeFlush;
            lu_cnt    <= '0;
            flush_cnt <= '0;
        end else if (bus.gwe) begin
            if (flush) begin
                code_d <= CodeFlush;
                code_x <= CodeFlush;
                if (flush_cnt != {CNT_W{1'b1}}) begin
                    flush_cnt <= flush_cnt + CNT_W'(1);
                end
            end else if (lu) begin
                code_x <= CodeLdUse;
                if (lu_cnt != {CNT_W{1'b1}}) begin
                    lu_cnt <= lu_cnt + CNT_W'(1);
                end
            end else begin
                code_x <= code_d;
                code_d <= CodeReal;
            end
            code_m <= code_x;
            code_w <= code_m;
        end
    end

    assign bus.o_stall_fd   = lu;
    assign bus.o_bubble_dx  = lu;
    assign bus.o_flush      = flush;
    assign bus.o_test_stall = code_w;
    assign bus.o_lu_cnt     = lu_cnt;
    assign bus.o_flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_lc4_hazard_ctrl.sv
// Scoreboard bench for lc4_hazard_ctrl: directed vectors push expected responses,
// a monitor checks combinational outputs at negedge and registered outputs after the edge.
module tb_lc4_hazard_ctrl;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic       r1re;
        logic [2:0] r1;
        logic       r2re;
        logic [2:0] r2;
        logic       st;
        logic       br;
        logic       ld;
        logic [2:0] rd;
        logic       tk;
    } vin_t;

    typedef struct packed {
        int         id;
        logic       sfd;
        logic       fl;
        logic [1:0] ts;
        logic [3:0] lu;
        logic [3:0] fc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;
    exp_t q[$];
    exp_t mon_e;

    lc4_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    lc4_hazard_ctrl #(
        .CNT_W      (CNT_W),
        .LD_BR_STALL(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string nm, int id, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, id, act, exp);
        end
    endfunction

    function automatic vin_t vin(logic r1re, logic [2:0] r1, logic r2re, logic [2:0] r2,
                                 logic st, logic br, logic ld, logic [2:0] rd, logic tk);
        vin_t v;
        v = '{r1re: r1re, r1: r1, r2re: r2re, r2: r2, st: st, br: br, ld: ld, rd: rd, tk: tk};
        return v;
    endfunction

    task automatic apply(input vin_t v, input logic g);
        bus.gwe             = g;
        bus.i_dec_r1re      = v.r1re;
        bus.i_dec_r1sel     = v.r1;
        bus.i_dec_r2re      = v.r2re;
        bus.i_dec_r2sel     = v.r2;
        bus.i_dec_is_store  = v.st;
        bus.i_dec_is_branch = v.br;
        bus.i_x_is_load     = v.ld;
        bus.i_x_rdsel       = v.rd;
        bus.i_x_br_taken    = v.tk;
    endtask

    // One pipeline cycle: inputs applied just after a rising edge, expectations queued.
    task automatic step(input vin_t v, input logic g, input logic sfd, input logic fl,
                        input logic [1:0] ts, input logic [3:0] lu, input logic [3:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v, g);
        vec_id++;
        e = '{id: vec_id, sfd: sfd, fl: fl, ts: ts, lu: lu, fc: fc};
        q.push_back(e);
    endtask

    // Monitor: comb outputs mid-cycle, registered outputs right after the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                check("stall_fd", mon_e.id, int'(bus.o_stall_fd), int'(mon_e.sfd));
                check("bubble_dx", mon_e.id, int'(bus.o_bubble_dx), int'(mon_e.sfd));
                check("flush", mon_e.id, int'(bus.o_flush), int'(mon_e.fl));
                @(posedge clk);
                #1;
                check("test_stall", mon_e.id, int'(bus.o_test_stall), int'(mon_e.ts));
                check("lu_cnt", mon_e.id, int'(bus.o_lu_cnt), int'(mon_e.lu));
                check("flush_cnt", mon_e.id, int'(bus.o_flush_cnt), int'(mon_e.fc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vin_t idle, ldu, ldu2;
        int   lu_exp;
        idle = '0;
        ldu  = vin(1, 3'd3, 0, 3'd0, 0, 0, 1, 3'd3, 0);
        ldu2 = vin(1, 3'd2, 0, 3'd0, 0, 0, 1, 3'd2, 0);
        rst  = 1'b1;
        apply(ldu, 1'b1);
        #3;
        check("rst_test_stall", 0, int'(bus.o_test_stall), 2);
        check("rst_stall_fd", 0, int'(bus.o_stall_fd), 0);
        check("rst_flush", 0, int'(bus.o_flush), 0);
        check("rst_lu_cnt", 0, int'(bus.o_lu_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        apply(idle, 1'b0);
        rst = 1'b0;

        // Fill after reset: 2,2,2 then first real insn in W on the 4th edge.
        step(idle, 1, 0, 0, 2'd2, 4'd0, 4'd0);
        step(idle, 1, 0, 0, 2'd2, 4'd0, 4'd0);
        step(idle, 1, 0, 0, 2'd2, 4'd0, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd0, 4'd0);

        // Load-use on r1; held inputs do not re-stall; code 3 in W two cycles later.
        step(ldu, 1, 1, 0, 2'd0, 4'd1, 4'd0);
        step(ldu, 1, 0, 0, 2'd0, 4'd1, 4'd0);
        step(idle, 1, 0, 0, 2'd3, 4'd1, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd1, 4'd0);

        // No-stall cases: other rd, r1 not read, X not a load, store data register.
        step(vin(1, 3'd3, 0, 3'd0, 0, 0, 1, 3'd4, 0), 1, 0, 0, 2'd0, 4'd1, 4'd0);
        step(vin(0, 3'd3, 0, 3'd0, 0, 0, 1, 3'd3, 0), 1, 0, 0, 2'd0, 4'd1, 4'd0);
        step(vin(1, 3'd3, 0, 3'd0, 0, 0, 0, 3'd3, 0), 1, 0, 0, 2'd0, 4'd1, 4'd0);
        step(vin(1, 3'd2, 1, 3'd5, 1, 0, 1, 3'd5, 0), 1, 0, 0, 2'd0, 4'd1, 4'd0);
        // Store whose base register is the load target stalls.
        step(vin(1, 3'd5, 1, 3'd5, 1, 0, 1, 3'd5, 0), 1, 1, 0, 2'd0, 4'd2, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd2, 4'd0);
        step(idle, 1, 0, 0, 2'd3, 4'd2, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd2, 4'd0);
        // Branch in D behind a load.
        step(vin(0, 3'd0, 0, 3'd0, 0, 1, 1, 3'd1, 0), 1, 1, 0, 2'd0, 4'd3, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd3, 4'd0);
        step(idle, 1, 0, 0, 2'd3, 4'd3, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd3, 4'd0);
        // Non-store r2 dependency.
        step(vin(0, 3'd0, 1, 3'd6, 0, 0, 1, 3'd6, 0), 1, 1, 0, 2'd0, 4'd4, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd4, 4'd0);
        step(idle, 1, 0, 0, 2'd3, 4'd4, 4'd0);
        step(idle, 1, 0, 0, 2'd0, 4'd4, 4'd0);

        // Taken branch with concurrent load-use: flush wins, two code-2 bubbles reach W.
        step(vin(1, 3'd3, 0, 3'd0, 0, 0, 1, 3'd3, 1), 1, 0, 1, 2'd0, 4'd4, 4'd1);
        step(vin(1, 3'd3, 0, 3'd0, 0, 0, 1, 3'd3, 1), 1, 0, 0, 2'd0, 4'd4, 4'd1);
        step(idle, 1, 0, 0, 2'd2, 4'd4, 4'd1);
        step(idle, 1, 0, 0, 2'd2, 4'd4, 4'd1);
        step(idle, 1, 0, 0, 2'd0, 4'd4, 4'd1);

        // Hazard held with gwe low: outputs asserted, no state change; then one gwe edge.
        step(ldu2, 0, 1, 0, 2'd0, 4'd4, 4'd1);
        step(ldu2, 0, 1, 0, 2'd0, 4'd4, 4'd1);
        step(ldu2, 0, 1, 0, 2'd0, 4'd4, 4'd1);
        step(ldu2, 1, 1, 0, 2'd0, 4'd5, 4'd1);
        step(idle, 1, 0, 0, 2'd0, 4'd5, 4'd1);

        // Reset mid-stall, away from any clock edge.
        @(posedge clk);
        #2;
        apply(ldu2, 1'b1);
        #1;
        check("pre_rst_stall_fd", 100, int'(bus.o_stall_fd), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_test_stall", 101, int'(bus.o_test_stall), 2);
        check("mid_rst_stall_fd", 101, int'(bus.o_stall_fd), 0);
        check("mid_rst_bubble_dx", 101, int'(bus.o_bubble_dx), 0);
        check("mid_rst_flush", 101, int'(bus.o_flush), 0);
        check("mid_rst_lu_cnt", 101, int'(bus.o_lu_cnt), 0);
        check("mid_rst_flush_cnt", 101, int'(bus.o_flush_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        apply(idle, 1'b0);
        rst = 1'b0;

        // Saturation: 4-bit load-use counter stops at 15.
        step(idle, 1, 0, 0, 2'd2, 4'd0, 4'd0);
        step(idle, 1, 0, 0, 2'd2, 4'd0, 4'd0);
        for (int k = 1; k <= 18; k++) begin
            lu_exp = (k > 15) ? 15 : k;
            step(ldu, 1, 1, 0, (k == 1) ? 2'd2 : 2'd3, 4'(lu_exp), 4'd0);
            step(idle, 1, 0, 0, 2'd0, 4'(lu_exp), 4'd0);
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", 200, q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lc4_hazard_ctrl.md
Name: lc4_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage LC4 pipeline (F, D, X, M, W). It detects load-use hazards between the D and X stages and taken control transfers resolved in X. It drives the fetch/decode hold, the D/X bubble insert and the F/D and D/X flush. It also carries a per-instruction stall code down to W, aligned with the writeback trace, and keeps saturating hazard event counters for the bench.

Parameters:
CNT_W, 16, width of the load-use and flush event counters (saturating)
LD_BR_STALL, 1, 1 = a BR in D stalls behind a load in X (NZP comes from the load's data)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
gwe  in  1  global write enable; all state advances only on clk rising edges with gwe=1
i_dec_r1sel  in  3  D-stage source register 1
i_dec_r1re  in  1  D-stage reads r1
i_dec_r2sel  in  3  D-stage source register 2
i_dec_r2re  in  1  D-stage reads r2
i_dec_is_store  in  1  D-stage insn is STR (opcode 0111); r2 is the store-data register
i_dec_is_branch  in  1  D-stage insn is BR (opcode 0000)
i_x_is_load  in  1  X-stage insn is LDR (opcode 0110)
i_x_rdsel  in  3  X-stage destination register
i_x_br_taken  in  1  X-stage control transfer redirects the PC
o_stall_fd  out  1  hold PC and F/D register
o_bubble_dx  out  1  load NOP into D/X
o_flush  out  1  kill F/D and D/X contents (load NOP)
o_test_stall  out  2  stall code of the insn currently in W
o_lu_cnt  out  CNT_W  load-use stall events
o_flush_cnt  out  CNT_W  flush events

Behaviour:
- Stall codes: 0 = real insn; 2 = bubble from reset or flush; 3 = load-use bubble. Code 1 is never produced.
- State: code_d, code_x, code_m, code_w (2 bits each); lu_cnt, flush_cnt.
- Reset (async, any time, including mid-stall): code_d = code_x = code_m = code_w = 2; counters = 0. All outputs reflect this immediately: o_test_stall = 2, o_stall_fd = o_bubble_dx = o_flush = 0 while rst=1.
- x_valid = (code_x == 0). Bubbles never raise hazards.
- Combinational hazard terms, not gated by gwe:
  - lu = x_valid & i_x_is_load & !flush, and any of:
    - i_dec_r1re & r1sel == rdsel
    - i_dec_r2re & r2sel == rdsel & !i_dec_is_store (store data is bypassed W->M, so no stall)
    - LD_BR_STALL & i_dec_is_branch
  - flush = x_valid & i_x_br_taken. Flush has priority over lu.
  - o_stall_fd = o_bubble_dx = lu; o_flush = flush.
- Sequential update on a clk edge with gwe=1 (no change at all when gwe=0):
  - flush: code_d <= 2, code_x <= 2; flush_cnt++ (saturates).
  - else lu: code_d holds; code_x <= 3; lu_cnt++ (saturates).
  - else: code_x <= code_d; code_d <= 0.
  - Always: code_m <= code_x; code_w <= code_m.
- o_test_stall = code_w, registered output.
- Latency: a bubble created in X appears on o_test_stall exactly 2 gwe-cycles later.
- Saturation: a counter at 2^CNT_W-1 stays at that value. It does not wrap.
- Back-to-back: a load-use stall holds D, so on the next cycle the load has left X and lu deasserts. At most one lu bubble per load.

Test Plan:
1. Reset release, then 4 gwe cycles with no hazards -> o_test_stall sequence 2,2,2,2,0. The first 0 appears on the 4th gwe edge (code_d fill + 3 shifts).
2. X = LDR rd=3; D = ADD r1sel=3, r1re=1 -> o_stall_fd = o_bubble_dx = 1 in that cycle. o_lu_cnt 0->1. o_test_stall = 3 two gwe-cycles later. Next cycle lu = 0.
3. X = LDR rd=5; D = STR, r2sel=5, r1sel=2 -> no stall. The same case with r1sel=5 (base register) -> stall, code 3.
4. x_valid, i_x_br_taken=1, with a concurrent lu condition also presented -> o_flush=1, o_stall_fd=0, flush_cnt +1, lu_cnt unchanged. Two bubbles (code 2,2) reach W on consecutive cycles.
5. Hazard held with gwe low for 3 clocks, then high 1 clock -> counters +1 only, and codes shift once. Assert rst mid-stall -> codes 2 and counters 0 immediately, without waiting for a clock.
6. CNT_W=4: 16 load-use events -> o_lu_cnt = 15 and it stays at 15.
